// File: rtl/wb_arb_pkg.sv
// ----------------------------------------------------------------------------
// wb_arb_pkg
//   Shared types and helpers for the Wishbone arbiters and bridges.
//   - arb_state_t : grant state of a two-master arbiter
//   - cnt_width() : width of an outstanding-request counter that must hold
//                   the values 0..max_out inclusive
// ----------------------------------------------------------------------------
package wb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    // Counter must represent 0..max_out, hence the +1.
    function automatic int cnt_width(input int max_out);
        return $clog2(max_out + 1);
    endfunction

endpackage : wb_arb_pkg

// File: rtl/wb_outstanding_ctr.sv
// ----------------------------------------------------------------------------
// wb_outstanding_ctr
//   Counts Wishbone requests that were accepted by a slave but not yet
//   acknowledged. Saturates at MAX_OUT and never underflows: an increment
//   while full or a decrement while empty is ignored. Simultaneous inc and
//   dec leave the count unchanged.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   i_inc    in   one request accepted this cycle (stb & ~stall)
//   i_dec    in   one request acknowledged this cycle (ack)
//   o_cnt    out  current count, CW bits
//   o_full   out  count == MAX_OUT
//   o_empty  out  count == 0
// ----------------------------------------------------------------------------
module wb_outstanding_ctr
    import wb_arb_pkg::*;
#(
    parameter int MAX_OUT = 4,
    parameter int CW      = cnt_width(MAX_OUT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_inc,
    input  logic          i_dec,
    output logic [CW-1:0] o_cnt,
    output logic          o_full,
    output logic          o_empty
);

    logic [CW-1:0] r_cnt;
    logic          w_inc;
    logic          w_dec;

    assign o_cnt   = r_cnt;
    assign o_full  = (r_cnt == CW'(MAX_OUT));
    assign o_empty = (r_cnt == '0);

    // A stray ack with nothing outstanding must not wrap the counter.
    assign w_inc = i_inc & ~o_full;
    assign w_dec = i_dec & ~o_empty;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge value regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else begin
            case ({w_inc, w_dec})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule : wb_outstanding_ctr

// File: rtl/wb_arbiter2.sv
// ----------------------------------------------------------------------------
// wb_arbiter2
//   Two-master, one-slave Wishbone B4 pipelined arbiter. m0 is the J1
//   instruction-fetch port, m1 the J1 data port or a loader. Grant is
//   round-robin at bus-cycle boundaries, locked while the granted master
//   holds cyc, and held until every accepted request has been acknowledged.
//   Arbitration costs one cycle: a strobe seen in IDLE is stalled, not lost.
//   All outputs are combinational from the registered state and inputs.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   m{0,1}_cyc/_stb/_we         master cycle, strobe, write enable
//   m{0,1}_adr [AW]             master address
//   m{0,1}_dat_m [DW]           master write data
//   m{0,1}_dat_s [DW]           read data to master (always s_dat_s)
//   m{0,1}_ack, m{0,1}_stall    acknowledge / stall to master
//   s_cyc/s_stb/s_we            slave cycle, strobe, write enable
//   s_adr [AW], s_dat_m [DW]    slave address, write data
//   s_dat_s [DW]                slave read data
//   s_ack, s_stall              slave acknowledge / stall
// ----------------------------------------------------------------------------
module wb_arbiter2
    import wb_arb_pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int MAX_OUT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    // master 0
    input  logic          m0_cyc,
    input  logic          m0_stb,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_adr,
    input  logic [DW-1:0] m0_dat_m,
    output logic [DW-1:0] m0_dat_s,
    output logic          m0_ack,
    output logic          m0_stall,
    // master 1
    input  logic          m1_cyc,
    input  logic          m1_stb,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_adr,
    input  logic [DW-1:0] m1_dat_m,
    output logic [DW-1:0] m1_dat_s,
    output logic          m1_ack,
    output logic          m1_stall,
    // slave
    output logic          s_cyc,
    output logic          s_stb,
    output logic          s_we,
    output logic [AW-1:0] s_adr,
    output logic [DW-1:0] s_dat_m,
    input  logic [DW-1:0] s_dat_s,
    input  logic          s_ack,
    input  logic          s_stall
);

    localparam int CW = cnt_width(MAX_OUT);

    arb_state_t    r_state;
    logic          r_last;       // last master served; 1 after reset so m0 wins the first tie

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_granted;
    logic          w_gnt_cyc;
    logic          w_gnt_stb;
    logic          w_release;
    logic          w_inc;
    logic [CW-1:0] w_cnt;
    logic          w_full;
    logic          w_empty;

    // ------------------------------------------------------------------
    // Outstanding-request tracking
    // ------------------------------------------------------------------
    assign w_inc = s_stb & ~s_stall;

    wb_outstanding_ctr #(
        .MAX_OUT (MAX_OUT),
        .CW      (CW)
    ) u_out_ctr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (w_inc),
        .i_dec   (s_ack),
        .o_cnt   (w_cnt),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // ------------------------------------------------------------------
    // Granted-master view
    // ------------------------------------------------------------------
    assign w_gnt0    = (r_state == GNT0);
    assign w_gnt1    = (r_state == GNT1);
    assign w_granted = w_gnt0 | w_gnt1;
    assign w_gnt_cyc = w_gnt1 ? m1_cyc : m0_cyc;
    assign w_gnt_stb = w_gnt1 ? m1_stb : m0_stb;

    // The bus is given up only once the owner has dropped cyc and the last
    // outstanding ack is either already in or arriving this cycle.
    assign w_release = w_granted & ~w_gnt_cyc &
                       (w_empty | ((w_cnt == CW'(1)) & s_ack));

    // ------------------------------------------------------------------
    // Slave side: keep cyc up while acks are pending even if the owner
    // has already dropped its own cyc, so late acks still reach it.
    // ------------------------------------------------------------------
    assign s_cyc   = w_granted & (w_gnt_cyc | ~w_empty);
    assign s_stb   = w_granted & w_gnt_stb & w_gnt_cyc & ~w_full;
    assign s_we    = w_gnt1 ? m1_we    : m0_we;
    assign s_adr   = w_gnt1 ? m1_adr   : m0_adr;
    assign s_dat_m = w_gnt1 ? m1_dat_m : m0_dat_m;

    // ------------------------------------------------------------------
    // Master side: a non-granted master is always stalled and never acked.
    // ------------------------------------------------------------------
    assign m0_stall = w_gnt0 ? (s_stall | w_full) : 1'b1;
    assign m1_stall = w_gnt1 ? (s_stall | w_full) : 1'b1;
    assign m0_ack   = w_gnt0 & s_ack;
    assign m1_ack   = w_gnt1 & s_ack;
    assign m0_dat_s = s_dat_s;
    assign m1_dat_s = s_dat_s;

    // ------------------------------------------------------------------
    // Grant FSM. Handover between masters is direct when the other master
    // is already waiting; IDLE is only entered when nobody requests.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m0_cyc && m1_cyc) begin
                        r_state <= r_last ? GNT0 : GNT1;
                    end else if (m0_cyc) begin
                        r_state <= GNT0;
                    end else if (m1_cyc) begin
                        r_state <= GNT1;
                    end
                end
                GNT0: begin
                    if (w_release) begin
                        r_last  <= 1'b0;
                        r_state <= m1_cyc ? GNT1 : IDLE;
                    end
                end
                GNT1: begin
                    if (w_release) begin
                        r_last  <= 1'b1;
                        r_state <= m0_cyc ? GNT0 : IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : wb_arbiter2

// File: tb/tb_wb_arbiter2.sv
// ----------------------------------------------------------------------------
// tb_wb_arbiter2
//   Directed bench for wb_arbiter2 (AW=DW=16, MAX_OUT=4). The slave is a
//   pipelined ROM returning adr ^ 16'hA5A5 with one cycle ack latency; its
//   acks can be withheld (sl_hold) or forced without a request (sl_spur).
//   Inputs change 1 ns after the rising edge, outputs are checked 1 ns later.
// ----------------------------------------------------------------------------
module tb_wb_arbiter2;

    logic        clk;
    logic        rst_n;
    logic        m0_cyc, m0_stb, m0_we;
    logic [15:0] m0_adr, m0_dat_m, m0_dat_s;
    logic        m0_ack, m0_stall;
    logic        m1_cyc, m1_stb, m1_we;
    logic [15:0] m1_adr, m1_dat_m, m1_dat_s;
    logic        m1_ack, m1_stall;
    logic        s_cyc, s_stb, s_we;
    logic [15:0] s_adr, s_dat_m, s_dat_s;
    logic        s_ack, s_stall;

    logic        sl_hold;
    logic        sl_spur;
    logic [4:0]  sq_wr, sq_rd;
    logic [15:0] sq_adr [16];
    logic        sl_pend;

    int n_cmp = 0;
    int n_err = 0;

    wb_arbiter2 #(.AW(16), .DW(16), .MAX_OUT(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_cyc   (m0_cyc),
        .m0_stb   (m0_stb),
        .m0_we    (m0_we),
        .m0_adr   (m0_adr),
        .m0_dat_m (m0_dat_m),
        .m0_dat_s (m0_dat_s),
        .m0_ack   (m0_ack),
        .m0_stall (m0_stall),
        .m1_cyc   (m1_cyc),
        .m1_stb   (m1_stb),
        .m1_we    (m1_we),
        .m1_adr   (m1_adr),
        .m1_dat_m (m1_dat_m),
        .m1_dat_s (m1_dat_s),
        .m1_ack   (m1_ack),
        .m1_stall (m1_stall),
        .s_cyc    (s_cyc),
        .s_stb    (s_stb),
        .s_we     (s_we),
        .s_adr    (s_adr),
        .s_dat_m  (s_dat_m),
        .s_dat_s  (s_dat_s),
        .s_ack    (s_ack),
        .s_stall  (s_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- pipelined ROM slave model ----------------
    assign sl_pend = (sq_wr != sq_rd);
    assign s_stall = 1'b0;
    assign s_ack   = (sl_pend & ~sl_hold) | sl_spur;
    assign s_dat_s = sl_pend ? (sq_adr[sq_rd[3:0]] ^ 16'hA5A5) : 16'h0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_wr <= '0;
            sq_rd <= '0;
        end else begin
            if (s_cyc && s_stb && !s_stall) begin
                sq_adr[sq_wr[3:0]] <= s_adr;
                sq_wr              <= sq_wr + 5'd1;
            end
            if (sl_pend && !sl_hold) sq_rd <= sq_rd + 5'd1;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat_m = '0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat_m = '0;
        sl_hold = 0; sl_spur = 0;

        // Reset state
        settle();
        check("rst_s_cyc",    32'(s_cyc),    32'd0);
        check("rst_s_stb",    32'(s_stb),    32'd0);
        check("rst_m0_stall", 32'(m0_stall), 32'd1);
        check("rst_m1_stall", 32'(m1_stall), 32'd1);
        check("rst_m0_ack",   32'(m0_ack),   32'd0);
        tick(); tick();

        // Tie from reset: m0 first, then direct handover to m1
        rst_n = 1'b1; m0_cyc = 1; m1_cyc = 1;
        settle();
        check("tie_idle_m0_stall", 32'(m0_stall), 32'd1);
        check("tie_idle_m1_stall", 32'(m1_stall), 32'd1);
        tick();
        settle();
        check("tie1_m0_stall", 32'(m0_stall), 32'd0);
        check("tie1_m1_stall", 32'(m1_stall), 32'd1);
        check("tie1_s_cyc",    32'(s_cyc),    32'd1);
        m0_cyc = 0;
        settle();
        check("tie1_drop_s_cyc", 32'(s_cyc), 32'd0);
        tick();
        settle();
        check("handover_m1_stall", 32'(m1_stall), 32'd0);
        check("handover_m0_stall", 32'(m0_stall), 32'd1);
        check("handover_s_cyc",    32'(s_cyc),    32'd1);
        m1_cyc = 0;
        tick();                                   // IDLE, last = m1
        m0_cyc = 1; m1_cyc = 1;
        tick();
        settle();
        check("tie2_m0_stall", 32'(m0_stall), 32'd0);
        check("tie2_m1_stall", 32'(m1_stall), 32'd1);
        m0_cyc = 0; m1_cyc = 0;
        tick();                                   // IDLE, last = m0
        m0_cyc = 1; m1_cyc = 1;
        tick();
        settle();
        check("tie3_m1_stall", 32'(m1_stall), 32'd0);
        check("tie3_m0_stall", 32'(m0_stall), 32'd1);
        m0_cyc = 0; m1_cyc = 0;
        tick();                                   // IDLE, last = m1

        // Single master: 4 back-to-back reads adr 0..3
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'd0;
        settle();
        check("rd_c0_m0_stall", 32'(m0_stall), 32'd1);
        check("rd_c0_s_stb",    32'(s_stb),    32'd0);
        tick();
        settle();
        check("rd_c1_s_stb",    32'(s_stb),    32'd1);
        check("rd_c1_s_adr",    32'(s_adr),    32'h0000);
        check("rd_c1_m0_stall", 32'(m0_stall), 32'd0);
        check("rd_c1_m0_ack",   32'(m0_ack),   32'd0);
        tick();
        m0_adr = 16'd1;
        settle();
        check("rd_c2_ack",      32'(m0_ack),   32'd1);
        check("rd_c2_dat",      32'(m0_dat_s), 32'hA5A5);
        check("rd_c2_s_adr",    32'(s_adr),    32'h0001);
        check("rd_c2_m1_stall", 32'(m1_stall), 32'd1);
        tick();
        m0_adr = 16'd2;
        settle();
        check("rd_c3_ack", 32'(m0_ack),   32'd1);
        check("rd_c3_dat", 32'(m0_dat_s), 32'hA5A4);
        tick();
        m0_adr = 16'd3;
        settle();
        check("rd_c4_ack", 32'(m0_ack),   32'd1);
        check("rd_c4_dat", 32'(m0_dat_s), 32'hA5A7);
        check("rd_c4_m1_stall", 32'(m1_stall), 32'd1);
        tick();
        m0_cyc = 0; m0_stb = 0;
        settle();
        check("rd_c5_ack",   32'(m0_ack),   32'd1);
        check("rd_c5_dat",   32'(m0_dat_s), 32'hA5A6);
        check("rd_c5_s_cyc", 32'(s_cyc),    32'd1);
        check("rd_c5_s_stb", 32'(s_stb),    32'd0);
        tick();
        settle();
        check("rd_c6_s_cyc",    32'(s_cyc),    32'd0);
        check("rd_c6_m0_stall", 32'(m0_stall), 32'd1);
        check("rd_c6_m0_ack",   32'(m0_ack),   32'd0);

        // Lock: m1 waits 10 cycles behind m0's open cycle
        m0_cyc = 1;
        tick();
        m1_cyc = 1; m1_we = 1; m1_adr = 16'h0BEE; m1_dat_m = 16'h1234;
        for (int i = 0; i < 10; i++) begin
            settle();
            check($sformatf("lock_m1_stall_%0d", i), 32'(m1_stall), 32'd1);
            tick();
        end
        m0_cyc = 0;
        settle();
        check("lock_rel_m1_stall", 32'(m1_stall), 32'd1);
        tick();
        settle();
        check("lock_gnt_m1_stall", 32'(m1_stall), 32'd0);
        check("lock_gnt_s_adr",    32'(s_adr),    32'h0BEE);
        check("lock_gnt_s_we",     32'(s_we),     32'd1);
        check("lock_gnt_s_dat_m",  32'(s_dat_m),  32'h1234);
        m1_cyc = 0; m1_we = 0;
        tick();                                   // IDLE, last = m1

        // Backpressure: acks withheld for 6 cycles
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'd4; sl_hold = 1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            settle();
            check($sformatf("bp_c%0d_m0_stall", i), 32'(m0_stall), 32'd0);
            tick();
        end
        settle();
        check("bp_c5_m0_stall", 32'(m0_stall), 32'd1);
        check("bp_c5_s_stb",    32'(s_stb),    32'd0);
        tick();
        settle();
        check("bp_c6_m0_stall", 32'(m0_stall), 32'd1);
        tick();
        sl_hold = 0;
        settle();
        check("bp_c7_m0_ack",   32'(m0_ack),   32'd1);
        check("bp_c7_m0_stall", 32'(m0_stall), 32'd1);
        tick();
        settle();
        check("bp_c8_m0_ack",   32'(m0_ack),   32'd1);
        check("bp_c8_m0_stall", 32'(m0_stall), 32'd0);
        check("bp_c8_s_stb",    32'(s_stb),    32'd1);
        tick();
        sl_hold = 1;
        settle();
        check("bp_c9_m0_stall", 32'(m0_stall), 32'd0);
        tick();
        settle();
        check("bp_c10_m0_stall", 32'(m0_stall), 32'd1);
        m0_cyc = 0; m0_stb = 0; sl_hold = 0;
        tick(); tick(); tick(); tick();
        settle();
        check("bp_drained_s_cyc", 32'(s_cyc), 32'd0);

        // Drain: m0 drops cyc with 2 acks pending, m1 waits
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'd1;
        tick();
        sl_hold = 1;
        tick();
        m0_adr = 16'd2;
        tick();
        m0_cyc = 0; m0_stb = 0; m1_cyc = 1; sl_hold = 0;
        settle();
        check("drn1_s_cyc",    32'(s_cyc),    32'd1);
        check("drn1_m0_ack",   32'(m0_ack),   32'd1);
        check("drn1_dat",      32'(m0_dat_s), 32'hA5A4);
        check("drn1_m1_stall", 32'(m1_stall), 32'd1);
        check("drn1_m1_ack",   32'(m1_ack),   32'd0);
        tick();
        settle();
        check("drn2_s_cyc",    32'(s_cyc),    32'd1);
        check("drn2_m0_ack",   32'(m0_ack),   32'd1);
        check("drn2_dat",      32'(m0_dat_s), 32'hA5A7);
        check("drn2_m1_stall", 32'(m1_stall), 32'd1);
        tick();
        settle();
        check("drn_gnt_m1_stall", 32'(m1_stall), 32'd0);
        check("drn_gnt_m0_stall", 32'(m0_stall), 32'd1);
        check("drn_gnt_m0_ack",   32'(m0_ack),   32'd0);
        m1_cyc = 0;
        tick();                                   // IDLE, last = m1

        // Spurious ack in IDLE must not disturb the counter
        sl_spur = 1;
        settle();
        check("spur_m0_ack", 32'(m0_ack), 32'd0);
        check("spur_m1_ack", 32'(m1_ack), 32'd0);
        tick();
        sl_spur = 0; m0_cyc = 1;
        tick();
        m0_cyc = 0;
        settle();
        check("spur_cnt0_s_cyc", 32'(s_cyc), 32'd0);
        tick();                                   // IDLE, last = m0

        // Asynchronous reset mid-burst with 2 requests outstanding
        m0_cyc = 1; m0_stb = 1; m0_adr = 16'd8; sl_hold = 1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        settle();
        check("mrst_s_cyc",    32'(s_cyc),    32'd0);
        check("mrst_m0_stall", 32'(m0_stall), 32'd1);
        check("mrst_m1_stall", 32'(m1_stall), 32'd1);
        check("mrst_m0_ack",   32'(m0_ack),   32'd0);
        tick();
        rst_n = 1'b1; sl_hold = 0;
        settle();
        check("mrst_idle_m0_stall", 32'(m0_stall), 32'd1);
        tick();
        settle();
        check("mrst_gnt_m0_stall", 32'(m0_stall), 32'd0);
        check("mrst_gnt_s_stb",    32'(s_stb),    32'd1);
        m0_cyc = 0; m0_stb = 0;
        tick(); tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_wb_arbiter2
